gpr_file_mp: RTL and testbench
==============================

Name: gpr_file_mp

Overview:
- Parametrised successor to the 8-entry GPR file: 2 read ports, 2 write ports, x86 sub-register (8/16/32-bit) access, same-cycle write-to-read bypass, per-register busy scoreboard.
- Sits between decode/issue (reads sources, marks destination busy) and the two writeback pipes (commit results, clear busy).

Parameters:
- NUM_REGS, 8, number of architectural registers (power of 2, >=8)
- DATA_W, 32, register width (>=32; sub-register logic acts on bits [15:0], upper bits untouched by partial writes)
- IDX_W, $clog2(NUM_REGS), index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd1_idx  in  IDX_W  read port 1 register index
- rd1_size  in  2  00=8-bit, 01=16-bit, 10/11=full width
- rd1_data  out  DATA_W  zero-extended read value
- rd1_busy  out  1  source register has pending writeback
- rd2_idx, rd2_size, rd2_data, rd2_busy  same as port 1
- wr0_en  in  1  write port 0 enable (ALU pipe)
- wr0_idx  in  IDX_W  destination index
- wr0_size  in  2  encoding as rd1_size
- wr0_data  in  DATA_W  write value (low bits used for partial sizes)
- wr1_en, wr1_idx, wr1_size, wr1_data  write port 1 (load pipe), same meaning
- iss_en  in  1  issue: mark destination busy
- iss_idx  in  IDX_W  full register index to mark busy

Behaviour:
- Reset (rst=1 at posedge): all registers = 0, all busy bits = 0. Read outputs are combinational, so rd*_data=0 and rd*_busy=0 from the cycle after the reset edge. rst overrides all write/issue inputs in that cycle.
- Sub-register mapping, size 00: idx<4 -> byte 0 of reg idx (AL..BL); 4<=idx<8 -> byte 1 of reg idx-4 (AH..BH); idx>=8 in 8-bit mode -> byte 0 of reg idx.
- Size 01 -> bits [15:0] of reg idx. Size 1x -> full register.
- Writes: on posedge, only the addressed bytes change; all other bits hold. Write latency is 1 cycle.
- Dual write: both ports are applied bytewise. On byte overlap, wr1 wins. Non-overlapping bytes of the same register (e.g. wr0 AL, wr1 AH) both land.
- Reads: combinational from storage merged with the same-cycle wr0/wr1 bytes (bypass, wr1 priority), then sub-register extracted and zero-extended to DATA_W.
- Scoreboard, per-register busy bit:
  - next busy = (busy & ~clr) | set.
  - set = iss_en at iss_idx.
  - clr = wr0_en at wr0_idx OR wr1_en at wr1_idx, regardless of size.
  - Simultaneous set and clear on the same register: set wins (busy stays 1).
- Busy outputs: rd*_busy = busy[mapped full reg] & ~(same-cycle write to that reg). The bypass therefore also hides busy.
- wr*_en=0: no storage or busy change.
- Out-of-range index (only possible when NUM_REGS is not a power of 2, which is disallowed) is not required to be handled.

Test Plan:
- Reset: rst=1 one cycle, rd1_idx=0, rd2_idx=7, both size 10 -> rd1_data=rd2_data=0, busy=0.
- Partial writes: write EAX=0xDEADBEEF full, then wr0 idx 4 size 00 data 0x12 (AH) -> EAX read = 0xDEAD12EF. Read idx 0 size 00 -> 0x000000EF; idx 4 size 00 -> 0x00000012.
- Dual write collision: wr0 ECX full 0x11111111 and wr1 ECX size 01 0xCAFE in the same cycle -> ECX = 0x1111CAFE. Repeat with both full writes (wr0 0xAAAAAAAA, wr1 0x55555555) -> ECX = 0x55555555.
- Bypass: wr0 EDX=0xCAFEBABE with rd1_idx=2 in the same cycle -> rd1_data=0xCAFEBABE before the edge; storage holds it after the edge.
- Scoreboard: iss_en idx 3 -> rd1_busy(idx 3)=1 next cycle. Same-cycle iss_en idx 3 + wr1 idx 3 -> still busy. Later wr0 idx 3 alone -> busy 0, and rd1_busy=0 already during the write cycle.
- Write protect / reset mid-operation: wr0_en=0 with data 0xBADF00D5 -> no change. rst=1 with wr0_en=1 and iss_en=1 -> register stays 0 and busy stays 0.

Source files
------------

// File: rtl/gpr_file_mp.sv
// Multi-ported x86-style GPR file: 2 read / 2 write ports, 8/16/full sub-register access,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module gpr_file_mp #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd1_idx,
  input  logic [1:0]        rd1_size,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_busy,
  input  logic [IDX_W-1:0]  rd2_idx,
  input  logic [1:0]        rd2_size,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_busy,
  input  logic              wr0_en,
  input  logic [IDX_W-1:0]  wr0_idx,
  input  logic [1:0]        wr0_size,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [IDX_W-1:0]  wr1_idx,
  input  logic [1:0]        wr1_size,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              iss_en,
  input  logic [IDX_W-1:0]  iss_idx
);

  localparam logic [DATA_W-1:0] MASK_B0 = DATA_W'(16'h00FF);
  localparam logic [DATA_W-1:0] MASK_B1 = DATA_W'(16'hFF00);
  localparam logic [DATA_W-1:0] MASK_W  = DATA_W'(16'hFFFF);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;

  logic [IDX_W-1:0]  wr0_reg, wr1_reg, rd1_reg, rd2_reg;
  logic [DATA_W-1:0] wr0_mask, wr1_mask, wr0_al, wr1_al;

  // 8-bit access to indices 4..7 selects byte 1 of the register four below (AH..BH)
  function automatic logic is_high(input logic [IDX_W-1:0] idx, input logic [1:0] size);
    return (size == 2'b00) && ((idx >> 2) == IDX_W'(1));
  endfunction

  function automatic logic [IDX_W-1:0] map_reg(input logic [IDX_W-1:0] idx,
                                               input logic [1:0] size);
    return is_high(idx, size) ? idx - IDX_W'(4) : idx;
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0] size);
    case (size)
      2'b00:   return is_high(idx, size) ? MASK_B1 : MASK_B0;
      2'b01:   return MASK_W;
      default: return '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] align(input logic [IDX_W-1:0] idx,
                                              input logic [1:0] size,
                                              input logic [DATA_W-1:0] data);
    return is_high(idx, size) ? (DATA_W'(data[7:0]) << 8) : data;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [IDX_W-1:0] idx,
                                                input logic [1:0] size,
                                                input logic [DATA_W-1:0] val);
    case (size)
      2'b00:   return is_high(idx, size) ? DATA_W'(val[15:8]) : DATA_W'(val[7:0]);
      2'b01:   return DATA_W'(val[15:0]);
      default: return val;
    endcase
  endfunction

  always_comb begin
    wr0_reg  = map_reg(wr0_idx, wr0_size);
    wr1_reg  = map_reg(wr1_idx, wr1_size);
    rd1_reg  = map_reg(rd1_idx, rd1_size);
    rd2_reg  = map_reg(rd2_idx, rd2_size);
    wr0_mask = lane_mask(wr0_idx, wr0_size);
    wr1_mask = lane_mask(wr1_idx, wr1_size);
    wr0_al   = align(wr0_idx, wr0_size, wr0_data);
    wr1_al   = align(wr1_idx, wr1_size, wr1_data);
  end

  // Next-state storage doubles as the bypass view; wr1 is merged last so it wins overlaps
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      clr[r]    = 1'b0;
      set[r]    = iss_en && (iss_idx == IDX_W'(r));
      if (wr0_en && (wr0_reg == IDX_W'(r))) begin
        regs_d[r] = (regs_d[r] & ~wr0_mask) | (wr0_al & wr0_mask);
        clr[r]    = 1'b1;
      end
      if (wr1_en && (wr1_reg == IDX_W'(r))) begin
        regs_d[r] = (regs_d[r] & ~wr1_mask) | (wr1_al & wr1_mask);
        clr[r]    = 1'b1;
      end
    end
    busy_d = (busy_q & ~clr) | set;
  end

  always_comb begin
    rd1_data = extract(rd1_idx, rd1_size, regs_d[rd1_reg]);
    rd2_data = extract(rd2_idx, rd2_size, regs_d[rd2_reg]);
    rd1_busy = busy_q[rd1_reg] & ~clr[rd1_reg];
    rd2_busy = busy_q[rd2_reg] & ~clr[rd2_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp: hand-computed vectors checked with immediate assertions.
module tb_gpr_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  rd1_idx = '0, rd2_idx = '0;
  logic [1:0]  rd1_size = 2'b10, rd2_size = 2'b10;
  logic [31:0] rd1_data, rd2_data;
  logic        rd1_busy, rd2_busy;
  logic        wr0_en = 1'b0, wr1_en = 1'b0;
  logic [2:0]  wr0_idx = '0, wr1_idx = '0;
  logic [1:0]  wr0_size = '0, wr1_size = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  logic        iss_en = 1'b0;
  logic [2:0]  iss_idx = '0;

  int vectors = 0;
  int miscompares = 0;

  gpr_file_mp #(.NUM_REGS(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .rd1_idx(rd1_idx), .rd1_size(rd1_size), .rd1_data(rd1_data), .rd1_busy(rd1_busy),
    .rd2_idx(rd2_idx), .rd2_size(rd2_size), .rd2_data(rd2_data), .rd2_busy(rd2_busy),
    .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_size(wr0_size), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_size(wr1_size), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_idx(iss_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr0(input logic [2:0] idx, input logic [1:0] size, input logic [31:0] data);
    wr0_en = 1'b1; wr0_idx = idx; wr0_size = size; wr0_data = data;
  endtask

  task automatic wr1(input logic [2:0] idx, input logic [1:0] size, input logic [31:0] data);
    wr1_en = 1'b1; wr1_idx = idx; wr1_size = size; wr1_data = data;
  endtask

  task automatic rd(input logic [2:0] i1, input logic [1:0] s1,
                    input logic [2:0] i2, input logic [1:0] s2);
    rd1_idx = i1; rd1_size = s1; rd2_idx = i2; rd2_size = s2;
    #1;
  endtask

  initial begin
    // reset
    rst = 1'b1; rd1_idx = 3'd0; rd2_idx = 3'd7;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rd1_data", rd1_data, 32'h0);
    chk("rst_rd2_data", rd2_data, 32'h0);
    chk("rst_rd1_busy", 32'(rd1_busy), 32'h0);
    chk("rst_rd2_busy", 32'(rd2_busy), 32'h0);

    // partial writes into EAX
    wr0(3'd0, 2'b10, 32'hDEADBEEF);
    tick();
    wr0(3'd4, 2'b00, 32'h00000012);
    tick();
    wr0_en = 1'b0;
    rd(3'd0, 2'b10, 3'd4, 2'b00);
    chk("eax_full", rd1_data, 32'hDEAD12EF);
    chk("ah_read", rd2_data, 32'h00000012);
    rd(3'd0, 2'b00, 3'd0, 2'b01);
    chk("al_read", rd1_data, 32'h000000EF);
    chk("ax_read", rd2_data, 32'h000012EF);

    // non-overlapping bytes of one register from both ports
    wr0(3'd0, 2'b00, 32'hFFFFFF34);
    wr1(3'd4, 2'b00, 32'hFFFFFF56);
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    rd(3'd0, 2'b10, 3'd0, 2'b10);
    chk("al_ah_dual", rd1_data, 32'hDEAD5634);

    // overlapping dual writes to ECX, wr1 wins
    wr0(3'd1, 2'b10, 32'h11111111);
    wr1(3'd1, 2'b01, 32'h0000CAFE);
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    rd(3'd1, 2'b10, 3'd5, 2'b00);
    chk("ecx_partial_coll", rd1_data, 32'h1111CAFE);
    chk("ch_read", rd2_data, 32'h000000CA);
    wr0(3'd1, 2'b10, 32'hAAAAAAAA);
    wr1(3'd1, 2'b10, 32'h55555555);
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    rd(3'd1, 2'b10, 3'd1, 2'b10);
    chk("ecx_full_coll", rd1_data, 32'h55555555);

    // bypass on EDX
    wr0(3'd2, 2'b10, 32'hCAFEBABE);
    rd(3'd2, 2'b10, 3'd6, 2'b00);
    chk("bypass_rd1", rd1_data, 32'hCAFEBABE);
    chk("bypass_dh", rd2_data, 32'h000000BA);
    tick();
    wr0_en = 1'b0;
    #1;
    chk("edx_stored", rd1_data, 32'hCAFEBABE);

    // scoreboard on EBX
    iss_en = 1'b1; iss_idx = 3'd3;
    tick();
    iss_en = 1'b0;
    rd(3'd3, 2'b10, 3'd7, 2'b00);
    chk("busy_after_iss", 32'(rd1_busy), 32'h1);
    chk("busy_bh_alias", 32'(rd2_busy), 32'h1);
    iss_en = 1'b1; iss_idx = 3'd3;
    wr1(3'd3, 2'b10, 32'h00000077);
    #1;
    chk("busy_hidden_wr1", 32'(rd1_busy), 32'h0);
    tick();
    iss_en = 1'b0; wr1_en = 1'b0;
    #1;
    chk("busy_set_wins", 32'(rd1_busy), 32'h1);
    wr0(3'd3, 2'b00, 32'h00000099);
    #1;
    chk("busy_hidden_wr0", 32'(rd1_busy), 32'h0);
    tick();
    wr0_en = 1'b0;
    #1;
    chk("busy_cleared", 32'(rd1_busy), 32'h0);
    chk("ebx_value", rd1_data, 32'h00000099);

    // write enable low: no change
    wr0_en = 1'b0; wr0_idx = 3'd2; wr0_size = 2'b10; wr0_data = 32'hBADF00D5;
    tick();
    rd(3'd2, 2'b10, 3'd2, 2'b10);
    chk("wr_disabled", rd1_data, 32'hCAFEBABE);

    // reset overrides write and issue
    rst = 1'b1;
    wr0(3'd5, 2'b10, 32'h12345678);
    iss_en = 1'b1; iss_idx = 3'd5;
    tick();
    rst = 1'b0; wr0_en = 1'b0; iss_en = 1'b0;
    rd(3'd5, 2'b10, 3'd0, 2'b10);
    chk("rst_wr_data", rd1_data, 32'h0);
    chk("rst_iss_busy", 32'(rd1_busy), 32'h0);
    chk("rst_eax", rd2_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
